uart_csr_fifo_regs: RTL and testbench

UART_CSR_FIFO_REGS -- requirements
Module: uart_csr_fifo_regs

---
 rtl/uart_csr_fifo_regs_if.sv | 26 ++
 rtl/uart_csr_fifo_regs.sv | 195 +++++++++++++++++++
 tb/tb_uart_csr_fifo_regs.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_csr_fifo_regs_if.sv
// Local register bus between a bus master and the UART CSR block.
// Writes and reads are single-cycle requests, each acknowledged one cycle later.
interface uart_csr_fifo_regs_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   waddr;
  logic [DATA_W-1:0]   wdata;
  logic                wen;
  logic [DATA_W/8-1:0] wstrb;
  logic                wready;
  logic [ADDR_W-1:0]   raddr;
  logic                ren;
  logic [DATA_W-1:0]   rdata;
  logic                rvalid;

  modport master (
    output waddr, wdata, wen, wstrb, raddr, ren,
    input  wready, rdata, rvalid
  );

  modport slave (
    input  waddr, wdata, wen, wstrb, raddr, ren,
    output wready, rdata, rvalid
  );
endinterface

// File: rtl/uart_csr_fifo_regs.sv
// UART control/status register block with an RX receive buffer and interrupt logic.
// Define UART_CSR_RXFIFO_EN for an RXFIFO_DEPTH-entry RX FIFO; otherwise a single holding register.
module uart_csr_fifo_regs #(
  parameter int          ADDR_W       = 16,
  parameter int          DATA_W       = 32,
  parameter int          BASE_ADDR    = 0,
  parameter int          RXFIFO_DEPTH = 8,
  parameter int          N_IRQ        = 2,
  parameter logic [31:0] ID_VALUE     = 32'hcafe0666
) (
  input  logic              clk,
  input  logic              rst,
  uart_csr_fifo_regs_if.slave bus,
  input  logic [7:0]        rx_data,
  input  logic              rx_ferr,
  input  logic              rx_perr,
  input  logic              rx_valid,
  input  logic              tx_busy,
  input  logic              tx_full,
  output logic [1:0]        ctrl_baud,
  output logic              ctrl_txen,
  output logic              ctrl_rxen,
  output logic              ctrl_txst,
  output logic [7:0]        lp_div,
  output logic              lp_en,
  input  logic [N_IRQ-1:0]  irq_src,
  output logic              irq
);

`ifdef UART_CSR_RXFIFO_EN
  localparam int DEPTH = RXFIFO_DEPTH;
`else
  localparam int DEPTH = 1;
  localparam int unused_rxfifo_depth = RXFIFO_DEPTH;
`endif
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [ADDR_W-1:0] A_DATA    = ADDR_W'(BASE_ADDR + 32'h04);
  localparam logic [ADDR_W-1:0] A_STAT    = ADDR_W'(BASE_ADDR + 32'h0C);
  localparam logic [ADDR_W-1:0] A_CTRL    = ADDR_W'(BASE_ADDR + 32'h10);
  localparam logic [ADDR_W-1:0] A_LPMODE  = ADDR_W'(BASE_ADDR + 32'h14);
  localparam logic [ADDR_W-1:0] A_INTSTAT = ADDR_W'(BASE_ADDR + 32'h20);
  localparam logic [ADDR_W-1:0] A_INTEN   = ADDR_W'(BASE_ADDR + 32'h24);
  localparam logic [ADDR_W-1:0] A_ID      = ADDR_W'(BASE_ADDR + 32'h40);

  typedef enum logic [2:0] {
    REG_NONE, REG_DATA, REG_STAT, REG_CTRL, REG_LPMODE, REG_INTSTAT, REG_INTEN, REG_ID
  } reg_e;

  typedef struct packed {
    logic       perr;
    logic       ferr;
    logic [7:0] data;
  } rx_entry_t;

  function automatic reg_e decode(input logic [ADDR_W-1:0] a);
    if (a == A_DATA)    return REG_DATA;
    if (a == A_STAT)    return REG_STAT;
    if (a == A_CTRL)    return REG_CTRL;
    if (a == A_LPMODE)  return REG_LPMODE;
    if (a == A_INTSTAT) return REG_INTSTAT;
    if (a == A_INTEN)   return REG_INTEN;
    if (a == A_ID)      return REG_ID;
    return REG_NONE;
  endfunction

  reg_e             wr_sel, rd_sel;
  logic [N_IRQ-1:0] irq_mask;
  logic [N_IRQ-1:0] int_wbits;
  logic [N_IRQ-1:0] intstat, inten;
  logic             ovf;
  logic [CW-1:0]    count;
  logic             empty, full, push_req, push, pop, ovf_set;
  rx_entry_t        rx_entry, head;
  logic [31:0]      rd_word;
  logic             unused_bits;

  assign unused_bits = ^{bus.wdata, bus.wstrb};

  assign wr_sel = bus.wen ? decode(bus.waddr) : REG_NONE;
  assign rd_sel = bus.ren ? decode(bus.raddr) : REG_NONE;

  always_comb begin
    for (int i = 0; i < N_IRQ; i++) irq_mask[i] = bus.wstrb[i / 8];
  end
  assign int_wbits = bus.wdata[N_IRQ-1:0] & irq_mask;

  assign rx_entry = '{perr: rx_perr, ferr: rx_ferr, data: rx_data};
  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign pop      = (rd_sel == REG_DATA) && !empty;
  assign push_req = rx_valid && ctrl_rxen;
  // A full buffer still accepts a push when the same cycle pops the head.
  assign push     = push_req && (!full || pop);
  assign ovf_set  = push_req && full && !pop;

`ifdef UART_CSR_RXFIFO_EN
  localparam int PW = $clog2(DEPTH);
  rx_entry_t       mem [DEPTH];
  logic [PW-1:0]   wptr, rptr;

  // NOTE: storage is not reset; count alone says which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= rx_entry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  assign head = mem[rptr];
`else
  rx_entry_t hold;

  always_ff @(posedge clk) begin
    if (push) hold <= rx_entry;
  end

  assign head = hold;
`endif

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    rd_word = '0;
    unique case (rd_sel)
      REG_DATA:    if (!empty) rd_word = {1'b1, 13'b0, head.perr, head.ferr, 8'b0, head.data};
      REG_STAT: begin
        rd_word[2]     = tx_busy;
        rd_word[4]     = empty;
        rd_word[8]     = tx_full;
        rd_word[9]     = ovf;
        rd_word[23:16] = 8'(count);
      end
      REG_CTRL:    rd_word = {26'b0, ctrl_rxen, ctrl_txen, 2'b0, ctrl_baud};
      REG_LPMODE:  rd_word = {lp_en, 23'b0, lp_div};
      REG_INTSTAT: rd_word = 32'(intstat);
      REG_INTEN:   rd_word = 32'(inten);
      REG_ID:      rd_word = ID_VALUE;
      default:     rd_word = '0;
    endcase
  end

  // NOTE: all state updates use non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.wready <= 1'b0;
      bus.rvalid <= 1'b0;
      bus.rdata  <= '0;
      ctrl_baud  <= '0;
      ctrl_txen  <= 1'b0;
      ctrl_rxen  <= 1'b0;
      ctrl_txst  <= 1'b0;
      lp_div     <= '0;
      lp_en      <= 1'b0;
      intstat    <= '0;
      inten      <= '0;
      irq        <= 1'b0;
      ovf        <= 1'b0;
      count      <= '0;
    end else begin
      bus.wready <= bus.wen;
      bus.rvalid <= bus.ren;
      bus.rdata  <= bus.ren ? DATA_W'(rd_word) : '0;

      ctrl_txst <= (wr_sel == REG_CTRL) && bus.wstrb[0] && bus.wdata[6];
      if (wr_sel == REG_CTRL && bus.wstrb[0]) begin
        ctrl_baud <= bus.wdata[1:0];
        ctrl_txen <= bus.wdata[4];
        ctrl_rxen <= bus.wdata[5];
      end

      if (wr_sel == REG_LPMODE) begin
        if (bus.wstrb[0]) lp_div <= bus.wdata[7:0];
        if (bus.wstrb[3]) lp_en  <= bus.wdata[31];
      end

      // Source set is OR'd in after the clear so a coincident set wins.
      intstat <= (intstat & ~((wr_sel == REG_INTSTAT) ? int_wbits : '0)) | irq_src;
      if (wr_sel == REG_INTEN) inten <= (inten & ~irq_mask) | int_wbits;
      irq <= |(intstat & inten);

      ovf <= ovf_set || (ovf && !((wr_sel == REG_STAT) && bus.wstrb[1] && bus.wdata[9]));

      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_csr_fifo_regs.sv
// Directed self-checking bench for uart_csr_fifo_regs; expected RX capacity follows UART_CSR_RXFIFO_EN.
module tb_uart_csr_fifo_regs;

`ifdef UART_CSR_RXFIFO_EN
  localparam int DEPTH = 8;
`else
  localparam int DEPTH = 1;
`endif

  localparam logic [15:0] A_DATA = 16'h04, A_STAT = 16'h0C, A_CTRL = 16'h10, A_LPMODE = 16'h14;
  localparam logic [15:0] A_INTSTAT = 16'h20, A_INTEN = 16'h24, A_ID = 16'h40;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = '0;
  logic       rx_ferr = 1'b0, rx_perr = 1'b0, rx_valid = 1'b0;
  logic       tx_busy = 1'b0, tx_full = 1'b0;
  logic [1:0] ctrl_baud;
  logic       ctrl_txen, ctrl_rxen, ctrl_txst;
  logic [7:0] lp_div;
  logic       lp_en;
  logic [1:0] irq_src = '0;
  logic       irq;

  int checks = 0;
  int errors = 0;

  uart_csr_fifo_regs_if #(.ADDR_W(16), .DATA_W(32)) bus ();

  uart_csr_fifo_regs #(
    .ADDR_W(16), .DATA_W(32), .BASE_ADDR(0), .RXFIFO_DEPTH(8), .N_IRQ(2), .ID_VALUE(32'hcafe0666)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus.slave),
    .rx_data(rx_data), .rx_ferr(rx_ferr), .rx_perr(rx_perr), .rx_valid(rx_valid),
    .tx_busy(tx_busy), .tx_full(tx_full),
    .ctrl_baud(ctrl_baud), .ctrl_txen(ctrl_txen), .ctrl_rxen(ctrl_rxen), .ctrl_txst(ctrl_txst),
    .lp_div(lp_div), .lp_en(lp_en), .irq_src(irq_src), .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic bus_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
    @(negedge clk);
    bus.waddr = a; bus.wdata = d; bus.wstrb = s; bus.wen = 1'b1;
    @(negedge clk);
    bus.wen = 1'b0; bus.wstrb = '0;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [31:0] d, output logic v);
    @(negedge clk);
    bus.raddr = a; bus.ren = 1'b1;
    @(negedge clk);
    bus.ren = 1'b0;
    d = bus.rdata; v = bus.rvalid;
  endtask

  task automatic rx_push(input logic [7:0] b, input logic fe, input logic pe);
    @(negedge clk);
    rx_data = b; rx_ferr = fe; rx_perr = pe; rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    logic v;
    bus.wen = 1'b1; bus.ren = 1'b1; bus.waddr = A_CTRL; bus.raddr = A_ID;
    bus.wdata = 32'h71; bus.wstrb = 4'hf;
    repeat (2) @(negedge clk);
    rst = 1'b0; bus.wen = 1'b0; bus.ren = 1'b0; bus.wstrb = '0;
    @(negedge clk);
    checks++; if (bus.wready !== 1'b0 || bus.rvalid !== 1'b0) begin errors++; $display("FAIL reset_ack wready %b rvalid %b want 0 0", bus.wready, bus.rvalid); end
    checks++; if (bus.rdata !== 32'h0 || irq !== 1'b0 || ctrl_txst !== 1'b0) begin errors++; $display("FAIL reset_outs rdata %h irq %b txst %b want 0", bus.rdata, irq, ctrl_txst); end
    checks++; if ({ctrl_baud, ctrl_txen, ctrl_rxen, lp_div, lp_en} !== 13'h0) begin errors++; $display("FAIL reset_ctrl got %h want 0", {ctrl_baud, ctrl_txen, ctrl_rxen, lp_div, lp_en}); end
    bus_read(A_ID, d, v);
    checks++; if (d !== 32'hcafe0666 || v !== 1'b1) begin errors++; $display("FAIL id_read got %h/%b want cafe0666/1", d, v); end
    bus_read(A_CTRL, d, v);
    checks++; if (d !== 32'h0 || v !== 1'b1) begin errors++; $display("FAIL ctrl_reset got %h/%b want 0/1", d, v); end
    bus_read(A_STAT, d, v);
    checks++; if (d !== 32'h10) begin errors++; $display("FAIL stat_reset got %h want 00000010", d); end
  endtask

  task automatic test_handshake;
    logic [31:0] d;
    logic v;
    @(negedge clk);
    bus.waddr = 16'h100; bus.wdata = 32'hffffffff; bus.wstrb = 4'hf; bus.wen = 1'b1;
    checks++; if (bus.wready !== 1'b0) begin errors++; $display("FAIL wready_early got %b want 0", bus.wready); end
    @(negedge clk);
    bus.wen = 1'b0;
    checks++; if (bus.wready !== 1'b1) begin errors++; $display("FAIL wready_pulse got %b want 1", bus.wready); end
    @(negedge clk);
    checks++; if (bus.wready !== 1'b0) begin errors++; $display("FAIL wready_single got %b want 0", bus.wready); end
    bus_read(A_ID, d, v);
    @(negedge clk);
    checks++; if (bus.rvalid !== 1'b0 || bus.rdata !== 32'h0) begin errors++; $display("FAIL rvalid_single rvalid %b rdata %h want 0 0", bus.rvalid, bus.rdata); end
    bus_read(16'h100, d, v);
    checks++; if (d !== 32'h0 || v !== 1'b1) begin errors++; $display("FAIL unmapped_read got %h/%b want 0/1", d, v); end
    bus_write(A_ID, 32'h12345678, 4'hf);
    bus_read(A_ID, d, v);
    checks++; if (d !== 32'hcafe0666) begin errors++; $display("FAIL id_readonly got %h want cafe0666", d); end
  endtask

  task automatic test_status;
    logic [31:0] d;
    logic v;
    tx_busy = 1'b1; tx_full = 1'b1;
    bus_read(A_STAT, d, v);
    checks++; if (d !== 32'h114) begin errors++; $display("FAIL stat_tx got %h want 00000114", d); end
    tx_busy = 1'b0; tx_full = 1'b0;
    bus_write(A_STAT, 32'hffffffff, 4'hf);
    bus_read(A_STAT, d, v);
    checks++; if (d !== 32'h10) begin errors++; $display("FAIL stat_ro got %h want 00000010", d); end
  endtask

  task automatic test_fifo;
    logic [31:0] d, exp;
    logic v;
    int cnt;
    logic ov;
    bus_write(A_CTRL, 32'h20, 4'hf);
    rx_push(8'h41, 1'b0, 1'b0);
    rx_push(8'h42, 1'b0, 1'b0);
    rx_push(8'h43, 1'b0, 1'b0);
    cnt = (DEPTH >= 3) ? 3 : DEPTH;
    ov = (DEPTH < 3);
    bus_read(A_STAT, d, v);
    exp = (32'(cnt) << 16) | (32'(ov) << 9);
    checks++; if (d !== exp) begin errors++; $display("FAIL stat_three got %h want %h", d, exp); end
    for (int i = 0; i < 4; i++) begin
      bus_read(A_DATA, d, v);
      exp = (i < cnt) ? 32'h80000041 + 32'(i) : 32'h0;
      checks++; if (d !== exp) begin errors++; $display("FAIL data_pop%0d got %h want %h", i, d, exp); end
    end
    bus_read(A_STAT, d, v);
    exp = 32'h10 | (32'(ov) << 9);
    checks++; if (d !== exp) begin errors++; $display("FAIL stat_drained got %h want %h", d, exp); end
    bus_write(A_STAT, 32'h200, 4'b0010);
    rx_push(8'h55, 1'b1, 1'b0);
    bus_read(A_DATA, d, v);
    checks++; if (d !== 32'h80010055) begin errors++; $display("FAIL data_ferr got %h want 80010055", d); end
    rx_push(8'haa, 1'b0, 1'b1);
    bus_read(A_DATA, d, v);
    checks++; if (d !== 32'h800200aa) begin errors++; $display("FAIL data_perr got %h want 800200aa", d); end
    bus_write(A_CTRL, 32'h00, 4'hf);
    rx_push(8'h11, 1'b0, 1'b0);
    bus_read(A_STAT, d, v);
    checks++; if (d !== 32'h10) begin errors++; $display("FAIL rxen_off got %h want 00000010", d); end
  endtask

  task automatic test_overflow;
    logic [31:0] d, exp;
    logic v;
    bus_write(A_CTRL, 32'h20, 4'hf);
    for (int i = 0; i <= DEPTH; i++) rx_push(8'h10 + 8'(i), 1'b0, 1'b0);
    bus_read(A_STAT, d, v);
    exp = (32'(DEPTH) << 16) | 32'h200;
    checks++; if (d !== exp) begin errors++; $display("FAIL stat_ovf got %h want %h", d, exp); end
    bus_write(A_STAT, 32'h200, 4'hf);
    bus_read(A_STAT, d, v);
    exp = 32'(DEPTH) << 16;
    checks++; if (d !== exp) begin errors++; $display("FAIL ovf_clear got %h want %h", d, exp); end
    @(negedge clk);
    bus.raddr = A_DATA; bus.ren = 1'b1; rx_data = 8'hee; rx_valid = 1'b1;
    @(negedge clk);
    bus.ren = 1'b0; rx_valid = 1'b0;
    checks++; if (bus.rdata !== 32'h80000010) begin errors++; $display("FAIL full_pushpop got %h want 80000010", bus.rdata); end
    bus_read(A_STAT, d, v);
    exp = 32'(DEPTH) << 16;
    checks++; if (d !== exp) begin errors++; $display("FAIL full_level got %h want %h", d, exp); end
    for (int k = 1; k <= DEPTH; k++) begin
      bus_read(A_DATA, d, v);
      exp = (k < DEPTH) ? 32'h80000010 + 32'(k) : 32'h800000ee;
      checks++; if (d !== exp) begin errors++; $display("FAIL drain%0d got %h want %h", k, d, exp); end
    end
    rx_push(8'h31, 1'b0, 1'b0);
    @(negedge clk);
    bus.raddr = A_DATA; bus.ren = 1'b1; rx_data = 8'h32; rx_valid = 1'b1;
    @(negedge clk);
    bus.ren = 1'b0; rx_valid = 1'b0;
    checks++; if (bus.rdata !== 32'h80000031) begin errors++; $display("FAIL pushpop_head got %h want 80000031", bus.rdata); end
    bus_read(A_STAT, d, v);
    checks++; if (d !== 32'h00010000) begin errors++; $display("FAIL pushpop_level got %h want 00010000", d); end
    bus_read(A_DATA, d, v);
    checks++; if (d !== 32'h80000032) begin errors++; $display("FAIL pushpop_next got %h want 80000032", d); end
  endtask

  task automatic test_ctrl;
    logic [31:0] d;
    logic v;
    @(negedge clk);
    bus.waddr = A_CTRL; bus.wdata = 32'h71; bus.wstrb = 4'hf; bus.wen = 1'b1;
    checks++; if (ctrl_txst !== 1'b0) begin errors++; $display("FAIL txst_early got %b want 0", ctrl_txst); end
    @(negedge clk);
    bus.wen = 1'b0;
    checks++; if ({ctrl_txst, ctrl_baud, ctrl_txen, ctrl_rxen} !== 5'b10111) begin errors++; $display("FAIL ctrl_outs got %b want 10111", {ctrl_txst, ctrl_baud, ctrl_txen, ctrl_rxen}); end
    @(negedge clk);
    checks++; if (ctrl_txst !== 1'b0) begin errors++; $display("FAIL txst_single got %b want 0", ctrl_txst); end
    bus_read(A_CTRL, d, v);
    checks++; if (d !== 32'h31) begin errors++; $display("FAIL ctrl_read got %h want 00000031", d); end
    bus_write(A_CTRL, 32'h02, 4'h0);
    bus_read(A_CTRL, d, v);
    checks++; if (d !== 32'h31) begin errors++; $display("FAIL ctrl_nostrb got %h want 00000031", d); end
    bus_write(A_CTRL, 32'h03, 4'h1);
    bus_read(A_CTRL, d, v);
    checks++; if (d !== 32'h03 || ctrl_baud !== 2'd3) begin errors++; $display("FAIL ctrl_baud3 got %h/%0d want 00000003/3", d, ctrl_baud); end
  endtask

  task automatic test_irq;
    logic [31:0] d;
    logic v;
    bus_write(A_INTEN, 32'h3, 4'hf);
    @(negedge clk); irq_src = 2'b10;
    @(negedge clk); irq_src = 2'b00;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_latency got %b want 0", irq); end
    @(negedge clk);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_set got %b want 1", irq); end
    bus_read(A_INTSTAT, d, v);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL intstat_set got %h want 00000002", d); end
    irq_src = 2'b10;
    bus_write(A_INTSTAT, 32'h2, 4'hf);
    bus_read(A_INTSTAT, d, v);
    checks++; if (d !== 32'h2 || irq !== 1'b1) begin errors++; $display("FAIL set_wins got %h/%b want 00000002/1", d, irq); end
    irq_src = 2'b00;
    bus_write(A_INTSTAT, 32'h2, 4'hf);
    @(negedge clk);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear got %b want 0", irq); end
    bus_read(A_INTSTAT, d, v);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL intstat_clear got %h want 0", d); end
    bus_write(A_INTEN, 32'h1, 4'hf);
    @(negedge clk); irq_src = 2'b10;
    @(negedge clk); irq_src = 2'b00;
    @(negedge clk);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_masked got %b want 0", irq); end
    bus_write(A_INTEN, 32'h2, 4'hf);
    @(negedge clk);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_unmask got %b want 1", irq); end
    bus_read(A_INTEN, d, v);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL inten_read got %h want 00000002", d); end
    bus_write(A_INTSTAT, 32'h3, 4'hf);
  endtask

  task automatic test_lpmode;
    logic [31:0] d;
    logic v;
    bus_write(A_LPMODE, 32'h800000ff, 4'b1000);
    checks++; if (lp_en !== 1'b1 || lp_div !== 8'h00) begin errors++; $display("FAIL lp_strb_hi got %b/%h want 1/00", lp_en, lp_div); end
    bus_read(A_LPMODE, d, v);
    checks++; if (d !== 32'h80000000) begin errors++; $display("FAIL lp_read1 got %h want 80000000", d); end
    bus_write(A_LPMODE, 32'h000000a5, 4'b0001);
    bus_read(A_LPMODE, d, v);
    checks++; if (d !== 32'h800000a5 || lp_div !== 8'ha5) begin errors++; $display("FAIL lp_read2 got %h/%h want 800000a5/a5", d, lp_div); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] d;
    logic v;
    bus_write(A_CTRL, 32'h20, 4'hf);
    rx_push(8'h77, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1; bus.ren = 1'b1; bus.raddr = A_ID;
    bus.wen = 1'b1; bus.waddr = A_CTRL; bus.wdata = 32'h71; bus.wstrb = 4'hf;
    @(negedge clk);
    rst = 1'b0; bus.ren = 1'b0; bus.wen = 1'b0; bus.wstrb = '0;
    checks++; if (bus.wready !== 1'b0 || bus.rvalid !== 1'b0 || bus.rdata !== 32'h0) begin errors++; $display("FAIL abort_ack wready %b rvalid %b rdata %h want 0", bus.wready, bus.rvalid, bus.rdata); end
    checks++; if ({ctrl_rxen, ctrl_txst, lp_en, lp_div, irq} !== 12'h0) begin errors++; $display("FAIL rst_outs got %h want 0", {ctrl_rxen, ctrl_txst, lp_en, lp_div, irq}); end
    @(negedge clk);
    checks++; if (bus.wready !== 1'b0 || bus.rvalid !== 1'b0) begin errors++; $display("FAIL abort_late wready %b rvalid %b want 0", bus.wready, bus.rvalid); end
    bus_read(A_STAT, d, v);
    checks++; if (d !== 32'h10) begin errors++; $display("FAIL rst_fifo got %h want 00000010", d); end
  endtask

  initial begin
    bus.waddr = '0; bus.wdata = '0; bus.wen = 1'b0; bus.wstrb = '0;
    bus.raddr = '0; bus.ren = 1'b0;
    test_reset();
    test_handshake();
    test_status();
    test_fifo();
    test_overflow();
    test_ctrl();
    test_irq();
    test_lpmode();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
